pma_tx_serializer: RTL and testbench
====================================

PMA_TX_SERIALIZER -- requirements
Module: pma_tx_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 10, parallel word width in bits.
REQ-002 SHALL have port CLK_5G  input  1  bit-rate clock; all state on its rising edge; one clock only.
REQ-003 SHALL have port Rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port Data_in  input  DATA_WIDTH  encoded word from the 8b/10b encoder.
REQ-005 SHALL have port Data_valid  input  1  Data_in is valid this cycle.
REQ-006 SHALL have port Data_ready  output  1  block accepts Data_in this cycle.
REQ-007 SHALL have port TxPolarity  input  1  quasi-static; 1 inverts the transmitted bit.
REQ-008 SHALL have port TxElecIdle  input  1  request electrical idle; sampled at word boundaries only.
REQ-009 SHALL have port TX_POS  output  1  serial data, positive leg.
REQ-010 SHALL have port TX_NEG  output  1  serial data, negative leg.
REQ-011 SHALL have port Word_Clk  output  1  registered divide-by-DATA_WIDTH word clock.
REQ-012 SHALL have port Underflow  output  1  one-cycle pulse on an empty-holding-register boundary.

Function
REQ-013 SHALL hold one holding register (Hold, Hold_full), one DATA_WIDTH shift register, a bit counter Bit_cnt 0..DATA_WIDTH-1, and an Idle flag.
REQ-014 SHALL increment Bit_cnt every cycle, wrapping DATA_WIDTH-1 -> 0; the wrap cycle (Bit_cnt==DATA_WIDTH-1) is the boundary.
REQ-015 SHALL drive Data_ready = !Hold_full || boundary; transfer occurs when Data_valid && Data_ready.
REQ-016 At the boundary SHALL: if TxElecIdle, set Idle, leave Hold untouched; else if Hold_full, load shift register from Hold, clear Idle, consume Hold; else set Idle, load zero, pulse Underflow next cycle.
REQ-017 Simultaneous consume and transfer at a boundary SHALL leave Hold_full=1 with the new word.
REQ-018 Off-boundary SHALL shift right one bit per cycle; transmission LSB first.
REQ-019 TX_POS SHALL be shift_reg[0] XOR TxPolarity and TX_NEG its complement; while Idle both SHALL be 0.
REQ-020 Latency: word loaded at boundary edge SHALL appear as bit 0 in the following cycle and bit DATA_WIDTH-1 DATA_WIDTH-1 cycles later, gap-free back-to-back.
REQ-021 Word_Clk SHALL be 1 for Bit_cnt 0..DATA_WIDTH/2-1, else 0.
REQ-022 Data_valid without Data_ready SHALL hold no state change; Data_in is not captured.

Reset
REQ-023 Rst_n low SHALL immediately clear Bit_cnt, shift register, Hold_full, Underflow, Word_Clk to 0, and set Idle (TX_POS=TX_NEG=0, Data_ready=1).
REQ-024 Reset mid-word SHALL discard the partial word and held word; after release counting restarts from Bit_cnt=0.

Configuration
REQ-025 Macro PMA_TX_PRBS7_EN SHALL add input Prbs_En; when high, each boundary loads DATA_WIDTH bits of PRBS7 (x^7+x^6+1, seed 7'h7F) instead of Hold, Hold not consumed, Underflow suppressed.
REQ-026 Without PMA_TX_PRBS7_EN the port and generator SHALL be absent; behaviour per REQ-016.

Structure
REQ-027 Shared package pma_pkg SHALL hold DATA_WIDTH default, K28.5 constants (10'b0101111100 / 10'b1010000011) and PRBS7 seed/taps.
REQ-028 PRBS7 generator SHALL be sub-module pma_prbs7_gen, instantiated only under PMA_TX_PRBS7_EN.

Verification
REQ-029 Reset release, Data_valid=0 -> TX_POS=TX_NEG=0 throughout, Underflow pulses once per 10 cycles.
REQ-030 Data_in=10'b0101111100, TxPolarity=0 -> TX_POS sequence 0,0,1,1,1,1,1,0,1,0, starting cycle after the boundary.
REQ-031 Same word, TxPolarity=1 -> TX_POS 1,1,0,0,0,0,0,1,0,1; TX_NEG complementary.
REQ-032 Continuous Data_valid with words 10'h2AA,10'h155 -> 20 gap-free bits, Data_ready high only on boundaries once Hold full, no Underflow.
REQ-033 TxElecIdle=1 over one boundary with Hold full -> outputs 0 for that word, held word sent at next boundary.
REQ-034 Rst_n low at Bit_cnt=4 -> outputs 0 within same cycle, Hold_full=0, Word_Clk=0.

Source files
------------

// File: rtl/pma_pkg.sv
// pma_pkg: shared constants for the PMA transmit path (word width, K28.5 symbols, PRBS7 polynomial).
package pma_pkg;
    localparam int         DATA_WIDTH_DEF = 10;
    localparam logic [9:0] K28_5_RDN      = 10'b0101111100;
    localparam logic [9:0] K28_5_RDP      = 10'b1010000011;
    localparam logic [6:0] PRBS7_SEED     = 7'h7F;
    localparam logic [6:0] PRBS7_TAPS     = 7'b1100000;
    function automatic logic prbs7_fb(input logic [6:0] s);
        return ^(s & PRBS7_TAPS);
    endfunction
endpackage

// File: rtl/pma_tx_serializer_if.sv
// pma_tx_serializer_if: parallel word handshake between the encoder and the serializer.
interface pma_tx_serializer_if
    import pma_pkg::*;
#(parameter int DATA_WIDTH = DATA_WIDTH_DEF);
    logic [DATA_WIDTH-1:0] Data_in;
    logic                  Data_valid;
    logic                  Data_ready;
    modport master (output Data_in, output Data_valid, input Data_ready);
    modport slave  (input Data_in, input Data_valid, output Data_ready);
endinterface

// File: rtl/pma_prbs7_gen.sv
// pma_prbs7_gen: PRBS7 (x^7+x^6+1) source producing WIDTH bits per advance, LSB first in time.
module pma_prbs7_gen
    import pma_pkg::*;
#(parameter int WIDTH = DATA_WIDTH_DEF)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_adv,
    output logic [WIDTH-1:0] o_word
);
    logic [6:0] r_state;
    logic [6:0] w_state_nxt;
    always_comb begin
        w_state_nxt = r_state;
        o_word      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            o_word[i]   = prbs7_fb(w_state_nxt);
            w_state_nxt = {w_state_nxt[5:0], o_word[i]};
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= PRBS7_SEED;
        else if (i_adv) r_state <= w_state_nxt;
endmodule

// File: rtl/pma_tx_serializer.sv
// pma_tx_serializer: word-to-bit serializer with holding register, elec-idle and underflow reporting.
// Optional PRBS7 test source enabled by defining PMA_TX_PRBS7_EN.
module pma_tx_serializer
    import pma_pkg::*;
#(parameter int DATA_WIDTH = DATA_WIDTH_DEF)
(
    input  logic                CLK_5G,
    input  logic                Rst_n,
    pma_tx_serializer_if.slave  s_if,
`ifdef PMA_TX_PRBS7_EN
    input  logic                Prbs_En,
`endif
    input  logic                TxPolarity,
    input  logic                TxElecIdle,
    output logic                TX_POS,
    output logic                TX_NEG,
    output logic                Word_Clk,
    output logic                Underflow
);
    localparam int             CW   = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0]  HALF = CW'(DATA_WIDTH / 2);

    logic [CW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [DATA_WIDTH-1:0] r_hold;
    logic                  r_hold_full;
    logic                  r_idle;
    logic                  r_word_clk;
    logic                  r_underflow;
    logic [CW-1:0]         w_cnt_nxt;
    logic                  w_boundary;
    logic                  w_xfer;
    logic                  w_consume;
    logic                  w_prbs_on;
    logic [DATA_WIDTH-1:0] w_prbs;
    logic                  w_bit;

`ifdef PMA_TX_PRBS7_EN
    assign w_prbs_on = Prbs_En;
    pma_prbs7_gen #(.WIDTH(DATA_WIDTH)) u_prbs (
        .clk    (CLK_5G),
        .rst_n  (Rst_n),
        .i_adv  (w_boundary && w_prbs_on && !TxElecIdle),
        .o_word (w_prbs)
    );
`else
    assign w_prbs_on = 1'b0;
    assign w_prbs    = '0;
`endif

    assign w_boundary      = r_bit_cnt == LAST;
    assign w_cnt_nxt       = w_boundary ? '0 : r_bit_cnt + 1'b1;
    assign s_if.Data_ready = !r_hold_full || w_boundary;
    assign w_xfer          = s_if.Data_valid && s_if.Data_ready;
    assign w_consume       = w_boundary && !TxElecIdle && !w_prbs_on && r_hold_full;
    assign w_bit           = r_shift[0] ^ TxPolarity;
    assign TX_POS          = !r_idle && w_bit;
    assign TX_NEG          = !r_idle && !w_bit;
    assign Word_Clk        = r_word_clk;
    assign Underflow       = r_underflow;

    always_ff @(posedge CLK_5G or negedge Rst_n)
        if (!Rst_n) begin
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_idle      <= 1'b1;
            r_word_clk  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_bit_cnt   <= w_cnt_nxt;
            r_word_clk  <= w_cnt_nxt < HALF;
            r_underflow <= w_boundary && !TxElecIdle && !w_prbs_on && !r_hold_full;
            // elec-idle wins over PRBS and held data; the held word waits for a later boundary
            if (w_boundary) begin
                r_idle  <= TxElecIdle || (!w_prbs_on && !r_hold_full);
                r_shift <= TxElecIdle ? '0 : w_prbs_on ? w_prbs : r_hold_full ? r_hold : '0;
            end else
                r_shift <= r_shift >> 1;
            // a same-edge consume and transfer leaves the new word held
            if (w_xfer) begin
                r_hold      <= s_if.Data_in;
                r_hold_full <= 1'b1;
            end else if (w_consume)
                r_hold_full <= 1'b0;
        end
endmodule

// File: tb/tb_pma_tx_serializer.sv
// tb_pma_tx_serializer: directed checks of idle/underflow, polarity, back-to-back words, elec-idle and reset.
module tb_pma_tx_serializer;
    logic clk = 1'b0;
    logic Rst_n;
    logic TxPolarity;
    logic TxElecIdle;
    logic TX_POS;
    logic TX_NEG;
    logic Word_Clk;
    logic Underflow;
    int   tests = 0;
    int   fails = 0;
    int   k     = 0;
    logic [9:0]  k285;
    logic [9:0]  k285_inv;
    logic [9:0]  w2aa;
    logic [19:0] exp20;

    pma_tx_serializer_if u_if ();

    pma_tx_serializer u_dut (
        .CLK_5G     (clk),
        .Rst_n      (Rst_n),
        .s_if       (u_if),
`ifdef PMA_TX_PRBS7_EN
        .Prbs_En    (1'b0),
`endif
        .TxPolarity (TxPolarity),
        .TxElecIdle (TxElecIdle),
        .TX_POS     (TX_POS),
        .TX_NEG     (TX_NEG),
        .Word_Clk   (Word_Clk),
        .Underflow  (Underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s at k=%0d: observed %0h expected %0h", tag, k, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        k++;
        @(negedge clk);
    endtask

    task automatic load(input logic [9:0] w);
        u_if.Data_in    = w;
        u_if.Data_valid = 1'b1;
        tick();
        u_if.Data_valid = 1'b0;
    endtask

    initial begin
        k285     = 10'b0101111100;
        k285_inv = 10'b1010000011;
        w2aa     = 10'h2AA;
        exp20    = {10'h155, 10'h2AA};
        Rst_n           = 1'b0;
        TxPolarity      = 1'b0;
        TxElecIdle      = 1'b0;
        u_if.Data_in    = '0;
        u_if.Data_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_pos", TX_POS, 0);
        chk("rst_neg", TX_NEG, 0);
        chk("rst_ready", u_if.Data_ready, 1);
        chk("rst_wclk", Word_Clk, 0);
        chk("rst_uflow", Underflow, 0);
        Rst_n = 1'b1;
        k = 0;
        // idle line, underflow once per word, word clock shape
        for (int i = 0; i < 30; i++) begin
            tick();
            chk("idle_pos", TX_POS, 0);
            chk("idle_neg", TX_NEG, 0);
            chk("idle_uflow", Underflow, 32'((k % 10) == 0));
            chk("idle_wclk", Word_Clk, 32'((k % 10) < 5));
        end
        // K28.5, normal polarity
        load(k285);
        chk("k_ready_full", u_if.Data_ready, 0);
        repeat (8) tick();
        chk("k_ready_bnd", u_if.Data_ready, 1);
        tick();
        chk("k_no_uflow", Underflow, 0);
        for (int i = 0; i < 10; i++) begin
            chk("k_pos", TX_POS, 32'(k285[i]));
            chk("k_neg", TX_NEG, 32'(!k285[i]));
            tick();
        end
        chk("k_uflow_after", Underflow, 1);
        chk("k_idle_after", TX_POS, 0);
        // K28.5, inverted polarity
        TxPolarity = 1'b1;
        load(k285);
        repeat (9) tick();
        for (int i = 0; i < 10; i++) begin
            chk("kinv_pos", TX_POS, 32'(k285_inv[i]));
            chk("kinv_neg", TX_NEG, 32'(!k285_inv[i]));
            tick();
        end
        chk("kinv_uflow", Underflow, 1);
        chk("kinv_idle_neg", TX_NEG, 0);
        TxPolarity = 1'b0;
        // back-to-back 2AA, 155 with continuous valid
        u_if.Data_in    = 10'h2AA;
        u_if.Data_valid = 1'b1;
        tick();
        repeat (8) begin
            chk("b2b_ready_full", u_if.Data_ready, 0);
            tick();
        end
        chk("b2b_ready_bnd", u_if.Data_ready, 1);
        u_if.Data_in = 10'h155;
        tick();
        for (int i = 0; i < 20; i++) begin
            chk("b2b_pos", TX_POS, 32'(exp20[i]));
            chk("b2b_uflow", Underflow, 0);
            chk("b2b_ready", u_if.Data_ready, 32'(i >= 9));
            if (i == 9) u_if.Data_valid = 1'b0;
            tick();
        end
        chk("b2b_uflow_end", Underflow, 1);
        // elec-idle over one boundary with the holding register full
        load(w2aa);
        repeat (8) tick();
        TxElecIdle = 1'b1;
        tick();
        TxElecIdle = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("eidle_pos", TX_POS, 0);
            chk("eidle_neg", TX_NEG, 0);
            chk("eidle_uflow", Underflow, 0);
            tick();
        end
        chk("eidle_resume_uflow", Underflow, 0);
        for (int i = 0; i < 10; i++) begin
            chk("eidle_resume_pos", TX_POS, 32'(w2aa[i]));
            tick();
        end
        chk("eidle_uflow_end", Underflow, 1);
        // asynchronous reset mid-word with a word held
        load(k285);
        repeat (9) tick();
        load(10'h155);
        repeat (3) tick();
        chk("mid_pos_pre", TX_POS, 32'(k285[4]));
        chk("mid_ready_pre", u_if.Data_ready, 0);
        chk("mid_wclk_pre", Word_Clk, 1);
        Rst_n = 1'b0;
        #1;
        chk("mid_rst_pos", TX_POS, 0);
        chk("mid_rst_neg", TX_NEG, 0);
        chk("mid_rst_ready", u_if.Data_ready, 1);
        chk("mid_rst_wclk", Word_Clk, 0);
        chk("mid_rst_uflow", Underflow, 0);
        @(negedge clk);
        Rst_n = 1'b1;
        k = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("post_rst_pos", TX_POS, 0);
            chk("post_rst_uflow", Underflow, 32'(k == 10));
            chk("post_rst_wclk", Word_Clk, 32'((k % 10) < 5));
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
